// File: rtl/fdu_pwr_seq.sv
// Power/reset sequencer for the two redundant processors behind the FDU arbiter.
// Each channel cycles RUN -> OFF -> SETTLE -> RUN. Only one channel may be in OFF/SETTLE at a time.
module fdu_pwr_seq #(
    parameter int OFF_CYCLES    = 25000000,
    parameter int SETTLE_CYCLES = 5000000,
    parameter int MAX_CYCLES    = 3,
    parameter int CNT_W         = 26
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [1:0] i_por,
    input  logic [1:0] i_clr_lockout,
    output logic [1:0] o_pwr_en,
    output logic [1:0] o_proc_rst_n,
    output logic [1:0] o_busy,
    output logic [1:0] o_lockout,
    output logic [3:0] o_cycle_cnt,
    output logic [5:0] o_dbg_state
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_OFF    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] OFF_LAST    = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMR_ONE     = CNT_W'(1);
    localparam logic [1:0]       MAX_CNT     = 2'(MAX_CYCLES);

    state_e           r_state [2];
    logic [CNT_W-1:0] r_timer [2];
    logic [1:0]       r_cnt   [2];
    logic [1:0]       r_por_d1;

    logic [1:0] w_req;
    logic [1:0] w_cnt_eff [2];
    logic [1:0] w_at_max;
    logic [1:0] w_want_off;
    logic [1:0] w_go_off;

    assign w_req = i_por & ~r_por_d1;

    // A clear in the same cycle as a request takes effect first, so all decisions use the cleared count.
    // When both channels want to power down together, channel 0 wins and channel 1 keeps waiting.
    always_comb begin
        w_at_max   = '0;
        w_want_off = '0;
        w_go_off   = '0;
        for (int i = 0; i < 2; i++) begin
            w_cnt_eff[i] = i_clr_lockout[i] ? 2'd0 : r_cnt[i];
            w_at_max[i]  = (w_cnt_eff[i] >= MAX_CNT);
            w_want_off[i] = (((r_state[i] == ST_RUN) && w_req[i]) || (r_state[i] == ST_WAIT))
                            && !w_at_max[i]
                            && (r_state[i ^ 1] != ST_OFF) && (r_state[i ^ 1] != ST_SETTLE);
        end
        w_go_off[0] = w_want_off[0];
        w_go_off[1] = w_want_off[1] && !w_want_off[0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_por_d1 <= '0;
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= ST_SETTLE;
                r_timer[i] <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_por_d1 <= i_por;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= w_cnt_eff[i];
                unique case (r_state[i])
                    ST_RUN: begin
                        if (w_req[i]) begin
                            if (w_at_max[i]) begin
                                r_state[i] <= ST_LOCKED;
                            end else if (w_go_off[i]) begin
                                r_state[i] <= ST_OFF;
                                r_timer[i] <= '0;
                                r_cnt[i]   <= 2'(w_cnt_eff[i] + 2'd1);
                            end else begin
                                r_state[i] <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (w_at_max[i]) begin
                            r_state[i] <= ST_LOCKED;
                        end else if (w_go_off[i]) begin
                            r_state[i] <= ST_OFF;
                            r_timer[i] <= '0;
                            r_cnt[i]   <= 2'(w_cnt_eff[i] + 2'd1);
                        end
                    end
                    ST_OFF: begin
                        if (r_timer[i] >= OFF_LAST) begin
                            r_state[i] <= ST_SETTLE;
                            r_timer[i] <= '0;
                        end else begin
                            r_timer[i] <= r_timer[i] + TMR_ONE;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_timer[i] >= SETTLE_LAST) begin
                            r_state[i] <= ST_RUN;
                            r_timer[i] <= '0;
                        end else begin
                            r_timer[i] <= r_timer[i] + TMR_ONE;
                        end
                    end
                    ST_LOCKED: begin
                        if (i_clr_lockout[i]) begin
                            r_state[i] <= ST_SETTLE;
                            r_timer[i] <= '0;
                        end
                    end
                    default: begin
                        r_state[i] <= ST_SETTLE;
                        r_timer[i] <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        o_pwr_en     = '0;
        o_proc_rst_n = '0;
        o_busy       = '0;
        o_lockout    = '0;
        for (int i = 0; i < 2; i++) begin
            unique case (r_state[i])
                ST_RUN: begin
                    o_pwr_en[i]     = 1'b1;
                    o_proc_rst_n[i] = 1'b1;
                end
                ST_WAIT: begin
                    o_pwr_en[i]     = 1'b1;
                    o_proc_rst_n[i] = 1'b1;
                    o_busy[i]       = 1'b1;
                end
                ST_OFF: begin
                    o_busy[i] = 1'b1;
                end
                ST_SETTLE: begin
                    o_pwr_en[i] = 1'b1;
                    o_busy[i]   = 1'b1;
                end
                ST_LOCKED: begin
                    o_lockout[i] = 1'b1;
                end
                default: begin
                    o_busy[i] = 1'b1;
                end
            endcase
        end
    end

    assign o_cycle_cnt = {r_cnt[1], r_cnt[0]};
    assign o_dbg_state = {r_state[1], r_state[0]};

endmodule

// File: tb/tb_fdu_pwr_seq.sv
// Bench for fdu_pwr_seq with OFF_CYCLES=10, SETTLE_CYCLES=5, MAX_CYCLES=2.
// Vector rows hold inputs for n cycles; each cycle's expected outputs go through exp_q.
module tb_fdu_pwr_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] por = 2'b00;
    logic [1:0] clr = 2'b00;
    logic [1:0] pwr_en, proc_rst_n, busy, lockout;
    logic [3:0] cycle_cnt;
    logic [5:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_edges;

    logic [11:0] exp_q[$];

    typedef struct {
        logic        rst_n;
        logic [1:0]  por;
        logic [1:0]  clr;
        int          n;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [64];
    int   n_vecs = 0;

    fdu_pwr_seq #(
        .OFF_CYCLES(10), .SETTLE_CYCLES(5), .MAX_CYCLES(2), .CNT_W(26)
    ) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_por(por), .i_clr_lockout(clr),
        .o_pwr_en(pwr_en), .o_proc_rst_n(proc_rst_n), .o_busy(busy),
        .o_lockout(lockout), .o_cycle_cnt(cycle_cnt), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Both supplies must never be off together while out of reset.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            n_checks++;
            if (pwr_en == 2'b00) begin
                n_errors++;
                $display("FAIL pwr_never_00 got=%b exp=not 00 at %0t", pwr_en, $time);
            end
        end
    end

    task automatic add(input logic rst_n, input logic [1:0] p, input logic [1:0] c, input int n,
                       input logic [1:0] e_pwr, input logic [1:0] e_rst, input logic [1:0] e_busy,
                       input logic [1:0] e_lock, input logic [3:0] e_cnt);
        vecs[n_vecs] = '{rst_n, p, c, n, {e_pwr, e_rst, e_busy, e_lock, e_cnt}};
        n_vecs++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic run_row(input int idx);
        logic [11:0] e;
        logic [11:0] got;
        for (int c = 0; c < vecs[idx].n; c++) begin
            reset_n = vecs[idx].rst_n;
            por     = vecs[idx].por;
            clr     = vecs[idx].clr;
            exp_q.push_back(vecs[idx].exp);
            @(posedge clk);
            #1;
            e   = exp_q.pop_front();
            got = {pwr_en, proc_rst_n, busy, lockout, cycle_cnt};
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL vec%0d cyc%0d pwr/rst/busy/lock/cnt got=%b_%b_%b_%b_%b exp=%b_%b_%b_%b_%b",
                         idx, c, got[11:10], got[9:8], got[7:6], got[5:4], got[3:0],
                         e[11:10], e[9:8], e[7:6], e[5:4], e[3:0]);
            end
        end
    endtask

    initial begin
        // reset, then release: 4 more SETTLE samples then RUN
        add(0, 2'b00, 2'b00, 3,  2'b11, 2'b00, 2'b11, 2'b00, 4'b0000);
        add(1, 2'b00, 2'b00, 4,  2'b11, 2'b00, 2'b11, 2'b00, 4'b0000);
        add(1, 2'b00, 2'b00, 2,  2'b11, 2'b11, 2'b00, 2'b00, 4'b0000);
        // single ch0 power cycle
        add(1, 2'b01, 2'b00, 10, 2'b10, 2'b10, 2'b01, 2'b00, 4'b0001);
        add(1, 2'b01, 2'b00, 5,  2'b11, 2'b10, 2'b01, 2'b00, 4'b0001);
        add(1, 2'b00, 2'b00, 2,  2'b11, 2'b11, 2'b00, 2'b00, 4'b0001);
        // simultaneous requests: ch0 first, ch1 waits until ch0 is back in RUN
        add(1, 2'b11, 2'b00, 10, 2'b10, 2'b10, 2'b11, 2'b00, 4'b0010);
        add(1, 2'b11, 2'b00, 5,  2'b11, 2'b10, 2'b11, 2'b00, 4'b0010);
        add(1, 2'b11, 2'b00, 1,  2'b11, 2'b11, 2'b10, 2'b00, 4'b0010);
        add(1, 2'b11, 2'b00, 10, 2'b01, 2'b01, 2'b10, 2'b00, 4'b0110);
        add(1, 2'b11, 2'b00, 5,  2'b11, 2'b01, 2'b10, 2'b00, 4'b0110);
        add(1, 2'b00, 2'b00, 2,  2'b11, 2'b11, 2'b00, 2'b00, 4'b0110);
        // clear in RUN only zeroes the count
        add(1, 2'b00, 2'b10, 1,  2'b11, 2'b11, 2'b00, 2'b00, 4'b0010);
        // ch1: two cycles, third request locks out
        add(1, 2'b10, 2'b00, 10, 2'b01, 2'b01, 2'b10, 2'b00, 4'b0110);
        add(1, 2'b10, 2'b00, 5,  2'b11, 2'b01, 2'b10, 2'b00, 4'b0110);
        add(1, 2'b00, 2'b00, 1,  2'b11, 2'b11, 2'b00, 2'b00, 4'b0110);
        add(1, 2'b10, 2'b00, 10, 2'b01, 2'b01, 2'b10, 2'b00, 4'b1010);
        add(1, 2'b10, 2'b00, 5,  2'b11, 2'b01, 2'b10, 2'b00, 4'b1010);
        add(1, 2'b00, 2'b00, 1,  2'b11, 2'b11, 2'b00, 2'b00, 4'b1010);
        add(1, 2'b10, 2'b00, 3,  2'b01, 2'b01, 2'b00, 2'b10, 4'b1010);
        add(1, 2'b00, 2'b00, 2,  2'b01, 2'b01, 2'b00, 2'b10, 4'b1010);
        add(1, 2'b10, 2'b00, 2,  2'b01, 2'b01, 2'b00, 2'b10, 4'b1010);
        // clear lockout: SETTLE 5 then RUN
        add(1, 2'b00, 2'b10, 1,  2'b11, 2'b01, 2'b10, 2'b00, 4'b0010);
        add(1, 2'b00, 2'b00, 4,  2'b11, 2'b01, 2'b10, 2'b00, 4'b0010);
        add(1, 2'b00, 2'b00, 1,  2'b11, 2'b11, 2'b00, 2'b00, 4'b0010);
        // ch0 at max: clear with request in same cycle is accepted with count 1
        add(1, 2'b01, 2'b01, 1,  2'b10, 2'b10, 2'b01, 2'b00, 4'b0001);
        // re-pulse during OFF is dropped
        add(1, 2'b00, 2'b00, 1,  2'b10, 2'b10, 2'b01, 2'b00, 4'b0001);
        add(1, 2'b01, 2'b00, 1,  2'b10, 2'b10, 2'b01, 2'b00, 4'b0001);
        add(1, 2'b00, 2'b00, 1,  2'b10, 2'b10, 2'b01, 2'b00, 4'b0001);
        // reset mid-OFF: counts lost, same response as power-up
        add(0, 2'b00, 2'b00, 2,  2'b11, 2'b00, 2'b11, 2'b00, 4'b0000);
        add(1, 2'b00, 2'b00, 4,  2'b11, 2'b00, 2'b11, 2'b00, 4'b0000);
        add(1, 2'b00, 2'b00, 2,  2'b11, 2'b11, 2'b00, 2'b00, 4'b0000);

        for (int v = 0; v < n_vecs; v++) begin
            run_row(v);
        end

        // ch1 requests while ch0 is OFF: it waits, then powers down the cycle after ch0 is back in RUN
        por = 2'b01;
        @(posedge clk);
        #1;
        check("h_ch0_off", {30'd0, pwr_en}, 32'h2);
        por = 2'b11;
        @(posedge clk);
        #1;
        check("h_ch1_wait_busy", {30'd0, busy}, 32'h3);
        check("h_ch1_wait_pwr", {30'd0, pwr_en}, 32'h2);
        n_edges = 2;
        while (pwr_en[1] && n_edges < 60) begin
            @(posedge clk);
            #1;
            n_edges++;
        end
        check("h_wait_len", n_edges, 32'd17);
        check("h_ch0_run_when_ch1_off", {30'd0, pwr_en}, 32'h1);
        check("h_counts", {28'd0, cycle_cnt}, 32'h5);
        por = 2'b00;
        repeat (20) @(posedge clk);
        #1;
        check("h_idle_end", {24'd0, pwr_en, proc_rst_n, busy, lockout}, 32'hF0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
